// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback path.
//   DATA_W     : register data width
//   REG_AW     : register address width
//   NUM_REGS   : architectural register count
//   wb_entry_t : one pending register write {rd, data}
//   reg_onehot : one-hot of a destination register (x0 never sets a bit)
package cpu_wb_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (r != '0) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of the writeback arbiter's producer and register-file signals.
//   ALU source    : alu_valid, alu_rd, alu_data -> alu_stall
//   multdiv source: md_valid, md_rd, md_data    -> md_ready
//   write port    : ctrl_writeEnable, ctrl_writeReg, data_writeReg
//   status        : pending_mask, queue_count
// Modports: slave (the arbiter), master (producers / register file side).
interface writeback_arbiter_if #(
  parameter int unsigned DEPTH = 4
);
  import cpu_wb_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                alu_valid;
  logic [REG_AW-1:0]   alu_rd;
  logic [DATA_W-1:0]   alu_data;
  logic                alu_stall;

  logic                md_valid;
  logic [REG_AW-1:0]   md_rd;
  logic [DATA_W-1:0]   md_data;
  logic                md_ready;

  logic                ctrl_writeEnable;
  logic [REG_AW-1:0]   ctrl_writeReg;
  logic [DATA_W-1:0]   data_writeReg;
  logic [NUM_REGS-1:0] pending_mask;
  logic [CW-1:0]       queue_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
    output alu_stall, md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           pending_mask, queue_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
    input  alu_stall, md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           pending_mask, queue_count
  );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t holding completed multdiv results.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, din      : enqueue (ignored when full)
//   pop, dout      : dequeue head (ignored when empty); dout is the current head
//   count/full/empty : registered occupancy
//   mem_nxt/vld_nxt  : next-edge slot contents and occupancy, so the owner can
//                      register a summary of the queue in step with it
module wb_fifo
  import cpu_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  wb_entry_t                 din,
  input  logic                      pop,
  output wb_entry_t                 dout,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output wb_entry_t [DEPTH-1:0]     mem_nxt,
  output logic [DEPTH-1:0]          vld_nxt
);

  localparam int unsigned PW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    do_push = push && (count_q != DEPTH[PW:0]);
    do_pop  = pop && (count_q != '0);
    mem_d   = mem_q;
    vld_d   = vld_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_pop) begin
      vld_d[rd_q] = 1'b0;
      rd_d        = rd_q + PW'(1);
    end
    if (do_push) begin
      mem_d[wr_q] = din;
      vld_d[wr_q] = 1'b1;
      wr_d        = wr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      vld_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      vld_q   <= vld_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign dout    = mem_q[rd_q];
  assign count   = count_q;
  assign full    = (count_q == DEPTH[PW:0]);
  assign empty   = (count_q == '0);
  assign mem_nxt = mem_d;
  assign vld_nxt = vld_d;

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges single-cycle ALU results and queued multdiv
// results onto one registered register-file write port.
//   clock, ctrl_reset_n : clock, asynchronous active-low reset
//   wb (slave)          : ALU/multdiv sources, write port, pending_mask,
//                         queue_count
// The ALU normally wins the port; the multdiv queue drains in idle ALU cycles
// and is forced out (stalling the ALU) after STARVE_LIMIT consecutive losses.
module writeback_arbiter
  import cpu_wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                ctrl_reset_n,
  writeback_arbiter_if.slave  wb
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]         count;
  logic                  full, empty;
  wb_entry_t             head, md_entry;
  wb_entry_t [DEPTH-1:0] slot_nxt;
  logic [DEPTH-1:0]      vld_nxt;
  logic                  force_pop, alu_take, md_push, pop;

  logic                  we_q, we_d;
  logic [REG_AW-1:0]     wreg_q, wreg_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [SW-1:0]         starve_q, starve_d;

  assign md_entry = '{rd: wb.md_rd, data: wb.md_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clock),
    .rst_n   (ctrl_reset_n),
    .push    (md_push),
    .din     (md_entry),
    .pop     (pop),
    .dout    (head),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .mem_nxt (slot_nxt),
    .vld_nxt (vld_nxt)
  );

  always_comb begin
    force_pop    = (starve_q == SW'(STARVE_LIMIT)) && !empty;
    wb.alu_stall = force_pop && wb.alu_valid;
    // full is decoded from the registered count only: no same-cycle pass-through.
    wb.md_ready  = !full;
    alu_take     = wb.alu_valid && !wb.alu_stall && (wb.alu_rd != '0);
    md_push      = wb.md_valid && wb.md_ready && (wb.md_rd != '0);

    pop       = 1'b0;
    we_d      = 1'b0;
    wreg_d    = '0;
    wdata_d   = '0;
    starve_d  = '0;
    if (force_pop) begin
      pop     = 1'b1;
      we_d    = 1'b1;
      wreg_d  = head.rd;
      wdata_d = head.data;
    end else if (alu_take) begin
      we_d    = 1'b1;
      wreg_d  = wb.alu_rd;
      wdata_d = wb.alu_data;
      if (!empty)
        starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    end else if (!empty) begin
      pop     = 1'b1;
      we_d    = 1'b1;
      wreg_d  = head.rd;
      wdata_d = head.data;
    end

    // Built from the queue's next-edge contents so the mask moves with it.
    pending_d = we_d ? reg_onehot(wreg_d) : '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_nxt[i]) pending_d = pending_d | reg_onehot(slot_nxt[i].rd);
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
      starve_q  <= '0;
    end else begin
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
      starve_q  <= starve_d;
    end
  end

  assign wb.ctrl_writeEnable = we_q;
  assign wb.ctrl_writeReg    = wreg_q;
  assign wb.data_writeReg    = wdata_q;
  assign wb.pending_mask     = pending_q;
  assign wb.queue_count      = count;

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, multdiv result queue entries (power of two, 2..16).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive preempted cycles before queue head is forced out.
REQ-003 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port ctrl_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports alu_valid/alu_rd/alu_data  input  1/5/32  single-cycle ALU result.
REQ-006 SHALL have port alu_stall  output  1  ALU result not accepted this cycle; upstream holds.
REQ-007 SHALL have ports md_valid/md_rd/md_data  input  1/5/32  multdiv completion beat.
REQ-008 SHALL have port md_ready  output  1  queue can accept md beat.
REQ-009 SHALL have ports ctrl_writeEnable/ctrl_writeReg/data_writeReg  output  1/5/32  registered register-file write port.
REQ-010 SHALL have port pending_mask  output  32  bit r set while a write to r is queued or on the write port.
REQ-011 SHALL have port queue_count  output  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-012 SHALL accept ALU beat when alu_valid && !alu_stall; SHALL accept md beat when md_valid && md_ready.
REQ-013 SHALL discard accepted beats with rd==0: never queued, never on write port, no pending_mask effect.
REQ-014 SHALL drive md_ready = (queue_count < DEPTH), combinational from registered count only; no full-queue pass-through.
REQ-015 Write-port selection per cycle, priority order: (a) forced head pop when starve counter == STARVE_LIMIT; (b) accepted ALU beat, rd!=0; (c) queue head if non-empty; (d) idle, ctrl_writeEnable=0.
REQ-016 SHALL assert alu_stall combinationally exactly when case (a) holds and alu_valid=1.
REQ-017 Starve counter SHALL increment on each cycle an ALU beat wins while queue non-empty, saturate at STARVE_LIMIT, clear on any head pop or when queue empty.
REQ-018 ALU latency: beat sampled at edge E SHALL appear on write port after edge E, valid for one cycle.
REQ-019 md latency: beat accepted at edge E SHALL enqueue at E; earliest write-port appearance after edge E+1.
REQ-020 Queue SHALL be strict FIFO; results SHALL reach the write port in acceptance order.
REQ-021 Simultaneous push and pop SHALL leave queue_count unchanged, including at count==DEPTH-1 and at count==1.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH with no lost or duplicated entry.
REQ-023 pending_mask SHALL be OR of one-hot(rd) over all queued entries plus ctrl_writeReg when ctrl_writeEnable=1; updated same edge as queue/port state.
REQ-024 Decode SHALL use pending_mask to stall readers and WAW writers; block does no hazard reordering.
REQ-025 When idle, ctrl_writeReg and data_writeReg SHALL be 0.

Reset
REQ-026 On ctrl_reset_n=0, asynchronously: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, queue empty, queue_count=0, pending_mask=0, starve counter=0.
REQ-027 During and after reset md_ready SHALL be 1 and alu_stall 0.
REQ-028 Reset mid-operation SHALL drop all queued entries; no write issues on first edge after deassertion unless alu_valid.

Structure
REQ-029 Shared package cpu_wb_pkg SHALL hold DATA_W=32, REG_AW=5, NUM_REGS=32 and struct wb_entry_t {rd, data}.
REQ-030 Queue SHALL be sub-module wb_fifo (synchronous FIFO of wb_entry_t, push/pop/count/full/empty, same clock/reset).
REQ-031 Write-port outputs and pending_mask SHALL be flops; only alu_stall and md_ready combinational.

Verification
REQ-032 ALU only: alu_valid, rd=3, data=0x1234 at edge 1 -> after edge 1 writeEnable=1, writeReg=3, data=0x1234; idle after edge 2.
REQ-033 Zero reg: alu rd=0 and md rd=0 beats -> writeEnable never 1, pending_mask stays 0, queue_count stays 0.
REQ-034 Fill/order: 4 md beats rd=5..8 while ALU busy -> md_ready=0 at count 4; on ALU idle, writes issue rd 5,6,7,8 in order, pending_mask clears bit by bit.
REQ-035 Starvation: queue holds rd=9, ALU valid every cycle -> 4 ALU writes, then alu_stall=1 for one cycle, rd=9 written, ALU resumes.
REQ-036 Simultaneous: count=3, push and pop same edge -> count stays 3, md_ready stays 1; pointers wrap after 8 beats with data intact.
REQ-037 Reset mid-op: queue count 3, ctrl_reset_n low between edges -> outputs 0 immediately, count 0, md_ready 1, no stale writes after release.
